// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR sequencing controller.
//   - default LFSR width, feedback taps, reset seed and counter width
//   - controller FSM state encoding
//   - Fibonacci LFSR next-state function
package lfsr_pkg;

  localparam int             LFSR_WIDTH        = 8;
  localparam logic [7:0]     LFSR_TAPS         = 8'hB8;  // x^8+x^6+x^5+x^4+1
  localparam logic [7:0]     LFSR_DEFAULT_SEED = 8'h01;
  localparam int             LFSR_CNT_W        = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Shift left, feed the parity of the tapped bits into bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
    input logic [LFSR_WIDTH-1:0] cur,
    input logic [LFSR_WIDTH-1:0] taps
  );
    return {cur[LFSR_WIDTH-2:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: LFSR state register with feedback.
//   clk, rst_n : clock, asynchronous active-low reset (state <= DEFAULT_SEED)
//   step       : advance the sequence by one word
//   load       : overwrite the state with load_val (wins over step)
//   load_val   : value to load; the caller guarantees it is non-zero
//   state      : current LFSR word
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DEFAULT_SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= lfsr_next(state, TAPS);
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: sequencing controller around an 8-bit Fibonacci LFSR.
//   clk, rst_n            : clock, asynchronous active-low reset
//   seed_in, seed_load    : load a non-zero seed (IDLE only); zero pulses err_zero
//   start, burst_len      : emit burst_len words on the out_* stream (IDLE only)
//   stop                  : abort a running burst
//   period_req            : measure the LFSR period (IDLE only)
//   out_data/out_valid/out_ready : valid/ready stream of LFSR words
//   busy                  : burst or measurement in progress
//   done                  : one-cycle pulse at the end of a burst
//   period_out/period_valid : last measured period and its update pulse
//   err_zero              : one-cycle pulse when a zero seed is rejected
// IDLE request priority: seed_load > period_req > start.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
  parameter int               CNT_W        = LFSR_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             seed_load,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             stop,
  input  logic             period_req,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             err_zero
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       fsm;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] ref_state;
  logic [WIDTH-1:0] state;

  logic             step;
  logic             load;
  logic             handshake;
  logic [WIDTH-1:0] stepped;
  logic [CNT_W-1:0] cnt_inc;

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    handshake = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    stepped   = lfsr_next(state, TAPS);
    cnt_inc   = (count == CNT_MAX) ? count : count + CNT_ONE;
    if (fsm == ST_RUN) begin
      handshake = out_valid & out_ready;
      step      = handshake;
    end
    if (fsm == ST_MEAS) begin
      step = 1'b1;
    end
    if (fsm == ST_IDLE && seed_load && seed_in != '0) begin
      load = 1'b1;
    end
  end

  lfsr_core #(
    .WIDTH       (WIDTH),
    .TAPS        (TAPS),
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (step),
    .load    (load),
    .load_val(seed_in),
    .state   (state)
  );

  // out_data is the state register itself, so it holds while stalled.
  assign out_data = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= ST_IDLE;
      remaining    <= '0;
      count        <= '0;
      ref_state    <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      err_zero     <= 1'b0;
    end else begin
      done         <= 1'b0;
      period_valid <= 1'b0;
      err_zero     <= 1'b0;

      case (fsm)
        ST_IDLE: begin
          if (seed_load) begin
            if (seed_in == '0) begin
              err_zero <= 1'b1;
            end
          end else if (period_req) begin
            ref_state <= state;
            count     <= '0;
            busy      <= 1'b1;
            fsm       <= ST_MEAS;
          end else if (start) begin
            if (burst_len != '0) begin
              remaining <= burst_len;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              fsm       <= ST_RUN;
            end else begin
              // Empty burst: report completion without emitting a word.
              done <= 1'b1;
              fsm  <= ST_DONE;
            end
          end
        end

        ST_RUN: begin
          if (handshake) begin
            remaining <= remaining - CNT_ONE;
          end
          // A handshake coinciding with stop has already been counted above.
          if ((handshake && remaining == CNT_ONE) || stop) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            fsm       <= ST_DONE;
          end
        end

        ST_MEAS: begin
          count <= cnt_inc;
          // Compare the value being stepped into, so the loop ends with the
          // state back at the reference word.
          if (stepped == ref_state || cnt_inc == CNT_MAX) begin
            period_out   <= cnt_inc;
            period_valid <= 1'b1;
            busy         <= 1'b0;
            fsm          <= ST_IDLE;
          end
        end

        ST_DONE: begin
          fsm <= ST_IDLE;
        end

        default: begin
          fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
